// File: rtl/if_stage.sv
// if_stage: RV32IM instruction fetch with busywait handshake, redirect/stall handling and IF/ID register.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_READ,
  input  logic        IMEM_BUSYWAIT,
  input  logic [31:0] IMEM_INSTR,
  output logic        FETCH_STALL,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PC_PLUS4,
  output logic [31:0] IF_ID_INSTR,
  output logic        IF_ID_VALID,
  output logic [6:0]  OPCODE,
  output logic [2:0]  FUNC3,
  output logic [6:0]  FUNC7,
  output logic [4:0]  RD,
  output logic [4:0]  RS1,
  output logic [4:0]  RS2
);
  typedef enum logic {S_FETCH, S_DROP} state_t;
  state_t      r_state, w_state_n;
  logic [31:0] r_pc, w_pc_n, r_drop_addr, w_drop_addr_n;
  logic [31:0] r_ifid_pc, r_ifid_pc4, r_ifid_instr;
  logic        r_ifid_valid;
  logic        w_load, w_bubble;
  logic [31:0] w_pc4, w_tgt;

  assign w_pc4       = r_pc + 32'd4;
  assign w_tgt       = BRANCH_TARGET & ~32'h3;
  assign IMEM_READ   = !RESET;
  // DROP keeps the abandoned address on the bus until memory finishes it
  assign IMEM_ADDR   = (r_state == S_DROP) ? r_drop_addr : r_pc;
  assign FETCH_STALL = IMEM_READ && IMEM_BUSYWAIT;

  always_comb begin
    w_state_n     = r_state;
    w_pc_n        = r_pc;
    w_drop_addr_n = r_drop_addr;
    w_load        = 1'b0;
    w_bubble      = 1'b0;
    if (r_state == S_DROP) begin
      w_pc_n    = BRANCH_TAKEN ? w_tgt : r_pc;
      w_bubble  = !STALL;
      w_state_n = IMEM_BUSYWAIT ? S_DROP : S_FETCH;
    end else if (BRANCH_TAKEN) begin
      w_pc_n        = w_tgt;
      w_bubble      = 1'b1;
      w_drop_addr_n = IMEM_BUSYWAIT ? r_pc : r_drop_addr;
      w_state_n     = IMEM_BUSYWAIT ? S_DROP : S_FETCH;
    end else if (!STALL) begin
      w_load   = !IMEM_BUSYWAIT;
      w_bubble = IMEM_BUSYWAIT;
      w_pc_n   = IMEM_BUSYWAIT ? r_pc : w_pc4;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_drop_addr  <= RESET_PC;
      r_ifid_pc    <= 32'd0;
      r_ifid_pc4   <= 32'd0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_pc        <= w_pc_n;
      r_drop_addr <= w_drop_addr_n;
      if (w_load) begin
        r_ifid_pc    <= r_pc;
        r_ifid_pc4   <= w_pc4;
        r_ifid_instr <= IMEM_INSTR;
        r_ifid_valid <= 1'b1;
      end else if (w_bubble) begin
        r_ifid_instr <= NOP_INSTR;
        r_ifid_valid <= 1'b0;
      end
    end
  end

  assign IF_ID_PC       = r_ifid_pc;
  assign IF_ID_PC_PLUS4 = r_ifid_pc4;
  assign IF_ID_INSTR    = r_ifid_instr;
  assign IF_ID_VALID    = r_ifid_valid;
  assign OPCODE         = r_ifid_instr[6:0];
  assign FUNC3          = r_ifid_instr[14:12];
  assign FUNC7          = r_ifid_instr[31:25];
  assign RD             = r_ifid_instr[11:7];
  assign RS1            = r_ifid_instr[19:15];
  assign RS2            = r_ifid_instr[24:20];
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and random fetch scenarios checked against a cycle-level behavioural model.
module tb_if_stage;
  logic        clk = 0, rst = 1, stall = 0, br = 0, busy = 0;
  logic [31:0] tgt = 0, imem_addr, imem_instr, ifid_pc, ifid_pc4, ifid_instr;
  logic        imem_read, fetch_stall, ifid_valid;
  logic [6:0]  opcode, func7;
  logic [2:0]  func3;
  logic [4:0]  rd, rs1, rs2;
  int n_cmp = 0, n_err = 0;

  logic [31:0] m_pc, m_daddr, m_ipc, m_ipc4, m_instr;
  bit          m_drop, m_valid;

  if_stage dut (
    .CLK(clk), .RESET(rst), .STALL(stall), .BRANCH_TAKEN(br), .BRANCH_TARGET(tgt),
    .IMEM_ADDR(imem_addr), .IMEM_READ(imem_read), .IMEM_BUSYWAIT(busy), .IMEM_INSTR(imem_instr),
    .FETCH_STALL(fetch_stall), .IF_ID_PC(ifid_pc), .IF_ID_PC_PLUS4(ifid_pc4),
    .IF_ID_INSTR(ifid_instr), .IF_ID_VALID(ifid_valid), .OPCODE(opcode), .FUNC3(func3),
    .FUNC7(func7), .RD(rd), .RS1(rs1), .RS2(rs2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
  endfunction

  assign imem_instr = mem(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_ifid();
    chk("if_id_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    chk("if_id_instr", ifid_instr, m_valid ? m_instr : 32'h13);
    chk("opcode", {25'd0, opcode}, m_valid ? {25'd0, m_instr[6:0]} : 32'h13);
    chk("fields", {func7, func3, rd, rs1, rs2},
        m_valid ? {m_instr[31:25], m_instr[14:12], m_instr[11:7], m_instr[19:15], m_instr[24:20]} : 25'd0);
    if (m_valid) begin
      chk("if_id_pc", ifid_pc, m_ipc);
      chk("if_id_pc4", ifid_pc4, m_ipc4);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1; stall = 0; br = 0; busy = 0;
    m_pc = 0; m_daddr = 0; m_drop = 0; m_valid = 0; m_ipc = 0; m_ipc4 = 0; m_instr = 32'h13;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      chk("rst_read", {31'd0, imem_read}, 32'd0);
      chk("rst_instr", ifid_instr, 32'h13);
      chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
      chk("rst_pc", ifid_pc | ifid_pc4, 32'd0);
    end
    rst = 0;
  endtask

  task automatic step(input bit s, input bit b, input logic [31:0] t, input bit w);
    logic [31:0] word;
    stall = s; br = b; tgt = t; busy = w;
    #1;
    chk("imem_read", {31'd0, imem_read}, 32'd1);
    chk("imem_addr", imem_addr, m_drop ? m_daddr : m_pc);
    chk("fetch_stall", {31'd0, fetch_stall}, {31'd0, w});
    word = mem(m_pc);
    if (m_drop) begin
      if (b) m_pc = t & ~32'h3;
      if (!s) m_valid = 0;
      if (!w) m_drop = 0;
    end else if (b) begin
      if (w) begin m_daddr = m_pc; m_drop = 1; end
      m_pc = t & ~32'h3;
      m_valid = 0;
    end else if (!s) begin
      if (!w) begin
        m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_instr = word; m_valid = 1; m_pc = m_pc + 32'd4;
      end else m_valid = 0;
    end
    @(posedge clk); #1;
    check_ifid();
  endtask

  initial begin
    do_reset(2);
    step(0, 0, 0, 0);
    chk("w0_opcode", {25'd0, opcode}, 32'b0010011);
    chk("w0_rd", {27'd0, rd}, 32'd1);
    chk("w0_rs1", {27'd0, rs1}, 32'd0);
    chk("w0_pc", ifid_pc, 32'd0);
    step(0, 0, 0, 0);
    chk("w1_rd", {27'd0, rd}, 32'd2);
    chk("w1_pc", ifid_pc, 32'd4);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("stall_addr", imem_addr, 32'h8);
    chk("stall_hold", ifid_pc, 32'h4);
    step(0, 0, 0, 0);
    chk("after_stall", ifid_pc, 32'h8);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      chk("busy_bubble", {31'd0, ifid_valid}, 32'd0);
    end
    step(0, 0, 0, 0);
    chk("busy_done", ifid_pc, 32'hC);
    step(1, 1, 32'h43, 0);
    chk("br_stall_addr", imem_addr, 32'h40);
    chk("br_stall_bubble", {31'd0, ifid_valid}, 32'd0);
    step(0, 1, 32'h10, 0);
    step(0, 1, 32'h100, 1);
    chk("drop_addr0", imem_addr, 32'h10);
    step(0, 0, 0, 1);
    chk("drop_addr1", imem_addr, 32'h10);
    step(0, 0, 0, 0);
    chk("drop_discard", {31'd0, ifid_valid}, 32'd0);
    chk("redirect_addr", imem_addr, 32'h100);
    step(0, 1, 32'hFFFF_FFFC, 0);
    step(0, 0, 0, 0);
    chk("wrap_pc4", ifid_pc4, 32'd0);
    chk("wrap_addr", imem_addr, 32'd0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 60) == 0) do_reset($urandom_range(1, 2));
      step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom, $urandom_range(0, 2) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
